gb_bus_master: RTL
==================

Name: gb_bus_master

Overview:
- Clocked Game Boy cartridge-bus initiator: drives the 16-bit address bus, data bus and CS/WR/RD strobes, which is the host side of the bus our cartridge MBC logic responds to.
- Used by the cart dumper/flasher and by the MBC bench as a cycle-accurate stand-in for the console.
- A simple host request/response port issues single read or write cycles with DMG-style phase timing.

Parameters:
PHASE_CYCLES, 4, CLK cycles per bus phase (SETUP, STROBE, HOLD); legal 1..255
CNT_W, 8, width of the phase counter; must hold PHASE_CYCLES-1

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-low
HOST_VALID  input  1  request valid
HOST_READY  output  1  block can accept a request
HOST_WE  input  1  1 = write cycle, 0 = read cycle
HOST_ADDR  input  16  bus address
HOST_WDATA  input  8  write data
RESP_VALID  output  1  one-cycle pulse: cycle complete
RESP_RDATA  output  8  read data, valid with RESP_VALID on reads
GB_A  output  16  cartridge address bus
GB_D_OUT  output  8  data driven to cart
GB_D_OE  output  1  1 = drive GB_D_OUT onto bus
GB_D_IN  input  8  data from cart
GB_CS  output  1  active-low cart RAM-region chip select
GB_WR  output  1  active-low write strobe
GB_RD  output  1  active-low read strobe
GB_RST  output  1  active-low cart reset

Behaviour:
- Reset: applies while RST=0, sampled on the CLK rising edge. Outputs during and after reset:
  - GB_A=0, GB_D_OUT=0, GB_D_OE=0.
  - GB_CS=1, GB_WR=1, GB_RD=1.
  - GB_RST=0.
  - HOST_READY=0, RESP_VALID=0, RESP_RDATA=0.
  - Any cycle in progress is abandoned; strobes release on that same edge.
- Leaving reset: on the first edge with RST=1, GB_RST goes 1 and HOST_READY goes 1.
- FSM states: IDLE, SETUP, STROBE, HOLD. Phase counter counts 0..PHASE_CYCLES-1 in each non-IDLE state. The state advances when the count equals PHASE_CYCLES-1, and the counter clears on every state change.
- IDLE:
  - HOST_READY=1.
  - On HOST_VALID=1: latch addr, we and wdata, then go to SETUP. HOST_READY drops on the next edge.
  - HOST_READY stays 0 in SETUP, STROBE and HOLD, so requests presented while busy are not accepted.
- SETUP:
  - GB_A = latched address.
  - GB_CS=0 if the address is in A000..FDFF, else 1.
  - Writes: GB_D_OE=1 and GB_D_OUT=wdata from the first SETUP cycle to the last HOLD cycle.
- STROBE:
  - Reads: GB_RD=0.
  - Writes: GB_WR=0.
  - The strobe lasts exactly PHASE_CYCLES clocks.
  - Reads sample GB_D_IN into RESP_RDATA on the last STROBE cycle.
- HOLD:
  - All strobes are back at 1; GB_A and GB_CS stay unchanged.
  - On the last HOLD cycle, RESP_VALID=1 for one clock and the FSM returns to IDLE.
  - GB_D_OE=0 and GB_CS=1 from IDLE entry.
- Latency: RESP_VALID is asserted 3*PHASE_CYCLES clocks after the accept edge. A new request may be accepted on the edge after RESP_VALID.
- RESP_RDATA holds its last read value; writes leave it unchanged.
- Invariants:
  - GB_D_OE=1 and GB_RD=0 are never true together.
  - GB_WR and GB_RD are never low together.
  - GB_A never changes while any strobe is low.
- All GB_* outputs are registered, so there are no combinational glitches on the strobes.

Optional Feature:
GB_BURST_EN
- Defined:
  - Adds input HOST_LEN[7:0], latched on accept; 0 means 256.
  - A read request with HOST_LEN>1 performs consecutive read cycles. The address increments mod 2^16 (FFFF wraps to 0000), and GB_CS is recomputed per byte.
  - Each byte produces its own RESP_VALID pulse.
  - HOLD of byte n goes directly to SETUP of byte n+1 without passing through IDLE. HOST_READY stays 0 until the final byte's RESP_VALID.
  - Writes ignore HOST_LEN and perform a single cycle.
- Undefined: the HOST_LEN port is absent and every request is a single cycle.

Test Plan:
- Reset/release: hold RST=0 for 3 clocks, then release -> GB_RST=0, GB_CS=GB_WR=GB_RD=1, HOST_READY=0 during reset; GB_RST=1 and HOST_READY=1 on the first edge after release.
- Single read, PHASE_CYCLES=4, addr 0x0100, cart returns 0xC3 -> GB_A=0x0100, GB_CS=1, GB_RD=0 for exactly 4 clocks, GB_D_OE=0 throughout; RESP_VALID 12 clocks after accept with RESP_RDATA=0xC3.
- Write 0x05 to 0x2000 -> GB_D_OE=1 and GB_D_OUT=0x05 for 12 clocks, GB_WR=0 for 4 clocks (clocks 5-8), GB_CS=1; RESP_RDATA unchanged.
- Read 0xA010 -> GB_CS=0 from SETUP through HOLD; read 0xFE00 -> GB_CS=1.
- HOST_VALID held high across two requests -> second request accepted only on the edge after the first RESP_VALID; RST=0 asserted mid-STROBE -> GB_RD=1, GB_RST=0, no RESP_VALID on that edge.
- GB_BURST_EN: read at 0xFFFE, HOST_LEN=3 -> GB_A sequence FFFE, FFFF, 0000; three RESP_VALID pulses 12 clocks apart; HOST_READY stays 0 until after the third.

Source files
------------

// File: rtl/gb_bus_master.sv
// gb_bus_master: clocked Game Boy cartridge-bus initiator.
// Host-side request/response port issues single read/write bus cycles with
// SETUP / STROBE / HOLD phases of PHASE_CYCLES clocks each.
// Optional feature macro: GB_BURST_EN (adds HOST_LEN and multi-byte reads).
// Every GB_* output and every host-facing output is a flop.

module gb_bus_master #(
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HOST_VALID,
  output logic        HOST_READY,
  input  logic        HOST_WE,
  input  logic [15:0] HOST_ADDR,
  input  logic [7:0]  HOST_WDATA,
`ifdef GB_BURST_EN
  input  logic [7:0]  HOST_LEN,
`endif
  output logic        RESP_VALID,
  output logic [7:0]  RESP_RDATA,
  output logic [15:0] GB_A,
  output logic [7:0]  GB_D_OUT,
  output logic        GB_D_OE,
  input  logic [7:0]  GB_D_IN,
  output logic        GB_CS,
  output logic        GB_WR,
  output logic        GB_RD,
  output logic        GB_RST
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0]  PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] RAM_LO     = 16'hA000;
  localparam logic [ADDR_W-1:0] RAM_HI     = 16'hFDFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_d;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_d;
  logic                we;
  logic                we_d;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   wdata_d;

  logic                phase_done;
  logic                accept;
  logic                more_bytes;
  logic                ram_sel;

  // Next values of the registered outputs
  logic                ready_d;
  logic                resp_valid_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [ADDR_W-1:0]   a_d;
  logic [DATA_W-1:0]   dout_d;
  logic                oe_d;
  logic                cs_d;
  logic                wr_d;
  logic                rd_d;

`ifdef GB_BURST_EN
  // Bytes still to transfer after the current one
  logic [7:0]          rem;
  logic [7:0]          rem_d;

  assign more_bytes = (rem != 8'd0);
`else
  assign more_bytes = 1'b0;
`endif

  assign phase_done = (cnt == PHASE_LAST);
  assign accept     = (state == S_IDLE) && HOST_READY && HOST_VALID;
  assign ram_sel    = (addr_d >= RAM_LO) && (addr_d <= RAM_HI);

  // State register: FSM state, phase counter and latched request
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      addr  <= '0;
      we    <= 1'b0;
      wdata <= '0;
`ifdef GB_BURST_EN
      rem   <= '0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      addr  <= addr_d;
      we    <= we_d;
      wdata <= wdata_d;
`ifdef GB_BURST_EN
      rem   <= rem_d;
`endif
    end
  end

  // Next-state logic: phase sequencing and request capture
  always_comb begin
    state_d = state;
    addr_d  = addr;
    we_d    = we;
    wdata_d = wdata;
`ifdef GB_BURST_EN
    rem_d   = rem;
`endif
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          addr_d  = HOST_ADDR;
          we_d    = HOST_WE;
          wdata_d = HOST_WDATA;
`ifdef GB_BURST_EN
          // Writes are always single; a length of 0 wraps to 255 more bytes
          rem_d   = HOST_WE ? 8'd0 : 8'(HOST_LEN - 8'd1);
`endif
        end
      end
      S_SETUP: begin
        if (phase_done) state_d = S_STROBE;
      end
      S_STROBE: begin
        if (phase_done) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (phase_done) begin
          if (more_bytes) begin
            state_d = S_SETUP;
            addr_d  = addr + 16'd1;
`ifdef GB_BURST_EN
            rem_d   = rem - 8'd1;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts on every phase change, including HOLD -> SETUP
    if ((state_d != state) || (state == S_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  // Output logic: values the output flops take on the coming edge
  always_comb begin
    ready_d      = (state_d == S_IDLE);
    a_d          = GB_A;
    dout_d       = GB_D_OUT;
    oe_d         = 1'b0;
    cs_d         = 1'b1;
    wr_d         = 1'b1;
    rd_d         = 1'b1;
    resp_valid_d = (state == S_HOLD) && phase_done;
    rdata_d      = RESP_RDATA;

    if (state_d != S_IDLE) begin
      a_d  = addr_d;
      cs_d = !ram_sel;
      oe_d = we_d;
      if (we_d) dout_d = wdata_d;
    end

    if (state_d == S_STROBE) begin
      wr_d = !we_d;
      rd_d = we_d;
    end

    // Read data is captured at the end of the last strobe clock
    if ((state == S_STROBE) && phase_done && !we) begin
      rdata_d = GB_D_IN;
    end
  end

  // Output registers: glitch-free strobes and host signals
  always_ff @(posedge CLK) begin
    if (!RST) begin
      HOST_READY <= 1'b0;
      RESP_VALID <= 1'b0;
      RESP_RDATA <= '0;
      GB_A       <= '0;
      GB_D_OUT   <= '0;
      GB_D_OE    <= 1'b0;
      GB_CS      <= 1'b1;
      GB_WR      <= 1'b1;
      GB_RD      <= 1'b1;
      GB_RST     <= 1'b0;
    end else begin
      HOST_READY <= ready_d;
      RESP_VALID <= resp_valid_d;
      RESP_RDATA <= rdata_d;
      GB_A       <= a_d;
      GB_D_OUT   <= dout_d;
      GB_D_OE    <= oe_d;
      GB_CS      <= cs_d;
      GB_WR      <= wr_d;
      GB_RD      <= rd_d;
      GB_RST     <= 1'b1;
    end
  end

endmodule
